piso_serializer_hs: RTL

//  Parametrised parallel-in/serial-out serializer with valid/ready input handshake.

---
 rtl/piso_pkg.sv | 16 +
 rtl/piso_bit_tick.sv | 31 +++
 rtl/piso_serializer_hs.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types, defaults and frame-length helper for the handshaked PISO serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV    = 1;

  function automatic int piso_frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/piso_bit_tick.sv
// Bit-period divider: bit_tick marks the final clk of each serial bit period.
module piso_bit_tick
  import piso_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic bit_tick
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  logic [DIV_W-1:0] div_cnt;

  // Restarting on load aligns the period to the first clk of a new frame.
  always_ff @(posedge clk) begin
    if (rst || load || !run) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign bit_tick = (CLK_DIV == 1) ? 1'b1 : (div_cnt == DIV_W'(CLK_DIV - 1));

endmodule

// File: rtl/piso_serializer_hs.sv
// Parallel-in/serial-out serializer with valid/ready input, one-word holding register
// for gapless frames, and an even-parity bit when PISO_PARITY_EN is defined.
module piso_serializer_hs
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  frame_start,
  output logic                  busy
);

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int FRAME_LEN = piso_frame_len(DATA_WIDTH, PARITY_EN);
  localparam int CNT_W     = $clog2(DATA_WIDTH + 2);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready is registered and equals "holding register empty next cycle".

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, hold_reg, load_word;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  hold_full, hold_full_nxt;
  logic                  accept, bit_tick, frame_end, shifting;
  logic                  load_in, load_hold, load_any, write_hold, next_bit, go_idle;
  logic                  next_val;

  assign accept    = in_valid && in_ready;
  assign shifting  = (state == SHIFT);
  assign frame_end = shifting && bit_tick && (bit_cnt == CNT_W'(FRAME_LEN));
  assign busy      = shifting || hold_full;

  piso_bit_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_bit_tick (
    .clk     (clk),
    .rst     (rst),
    .load    (load_any),
    .run     (shifting),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (frame_end && !hold_full && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // At frame end the held word wins; a same-cycle accept can only happen with the hold empty.
  always_comb begin
    load_in    = 1'b0;
    load_hold  = 1'b0;
    write_hold = 1'b0;
    next_bit   = 1'b0;
    go_idle    = 1'b0;
    case (state)
      IDLE: load_in = accept;
      SHIFT: begin
        if (frame_end) begin
          if (hold_full)   load_hold = 1'b1;
          else if (accept) load_in   = 1'b1;
          else             go_idle   = 1'b1;
        end else begin
          next_bit   = bit_tick;
          write_hold = accept;
        end
      end
      default: ;
    endcase
  end

  assign load_any  = load_in || load_hold;
  assign load_word = load_hold ? hold_reg : in_data;

  always_comb begin
    hold_full_nxt = hold_full;
    if (write_hold)     hold_full_nxt = 1'b1;
    else if (load_hold) hold_full_nxt = 1'b0;
  end

`ifdef PISO_PARITY_EN
  logic parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (load_any) begin
      parity <= ^load_word;
    end
  end

  always_comb begin
    next_val = MSB_FIRST ? shift_reg[DATA_WIDTH-1] : shift_reg[0];
    if (bit_cnt == CNT_W'(DATA_WIDTH)) next_val = parity;
  end
`else
  always_comb begin
    next_val = MSB_FIRST ? shift_reg[DATA_WIDTH-1] : shift_reg[0];
  end
`endif

  // ser_out holds the current bit; shift_reg holds the bits still to go.
  always_ff @(posedge clk) begin
    if (rst) begin
      ser_out     <= IDLE_LEVEL;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      in_ready    <= 1'b1;
      hold_full   <= 1'b0;
      hold_reg    <= '0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
    end else begin
      frame_start <= load_any;
      hold_full   <= hold_full_nxt;
      in_ready    <= !hold_full_nxt;
      if (write_hold) hold_reg <= in_data;
      if (load_any) begin
        ser_valid <= 1'b1;
        bit_cnt   <= CNT_W'(1);
        if (MSB_FIRST) begin
          ser_out   <= load_word[DATA_WIDTH-1];
          shift_reg <= load_word << 1;
        end else begin
          ser_out   <= load_word[0];
          shift_reg <= load_word >> 1;
        end
      end else if (next_bit) begin
        ser_out   <= next_val;
        bit_cnt   <= bit_cnt + CNT_W'(1);
        shift_reg <= MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
      end else if (go_idle) begin
        ser_out   <= IDLE_LEVEL;
        ser_valid <= 1'b0;
        bit_cnt   <= '0;
      end
    end
  end

endmodule
